// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the unified-memory port shared by cpu0 and cpu1,
// sequencing IDLE -> ISSUE -> WAIT -> DONE with a watchdog on the memory ready.
module mem_port_arbiter #(
  parameter int ADDR_W = 13,
  parameter int TMO_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [1:0]        op_0,
  input  logic [1:0]        op_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              mem_rdy,
  output logic              grant_0,
  output logic              grant_1,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              done_0,
  output logic              done_1,
  output logic              tmo_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state;
  logic              last_winner;
  logic [TMO_W-1:0]  wd;
  logic [TMO_W-1:0]  wd_n;
  logic              pick_1;
  logic [1:0]        op_w;
  // cpu1 wins when alone, or on a tie when cpu0 was served last
  assign pick_1 = req_1 & (~req_0 | ~last_winner);
  assign op_w   = pick_1 ? op_1 : op_0;
  assign wd_n   = wd + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      wd          <= '0;
      grant_0     <= 1'b0;
      grant_1     <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_0 | req_1) begin
          grant_0  <= ~pick_1;
          grant_1  <= pick_1;
          mem_addr <= pick_1 ? addr_1 : addr_0;
          mem_we   <= op_w == 2'b01;
          mem_re   <= op_w != 2'b01;
          state    <= ISSUE;
        end
        ISSUE: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          wd     <= '0;
          state  <= WAIT;
        end
        WAIT: if (mem_rdy || wd_n == '1) begin
          done_0  <= grant_0;
          done_1  <= grant_1;
          tmo_err <= ~mem_rdy;
          state   <= DONE;
        end else begin
          wd <= wd_n;
        end
        DONE: begin
          last_winner <= grant_1;
          grant_0     <= 1'b0;
          grant_1     <= 1'b0;
          done_0      <= 1'b0;
          done_1      <= 1'b0;
          tmo_err     <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, req_0, req_1, mem_rdy;
  logic [1:0]  op_0, op_1;
  logic [12:0] addr_0, addr_1;
  logic        grant_0, grant_1, mem_re, mem_we, done_0, done_1, tmo_err;
  logic [12:0] mem_addr;
  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1), .op_0(op_0), .op_1(op_1),
    .addr_0(addr_0), .addr_1(addr_1), .mem_rdy(mem_rdy), .grant_0(grant_0), .grant_1(grant_1),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .done_0(done_0), .done_1(done_1),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 32'({grant_1, grant_0, mem_re, mem_we, done_1, done_0, tmo_err}), 32'h0);
  endtask

  // Full transaction from the arbitration edge; winner w drops its request after done.
  task automatic txn(input bit w, input bit we, input logic [12:0] addr, input int waits);
    step;
    chk("grant", 32'({grant_1, grant_0}), w ? 32'h2 : 32'h1);
    chk("strobe", 32'({mem_we, mem_re}), we ? 32'h2 : 32'h1);
    chk("addr", 32'(mem_addr), 32'(addr));
    step;
    chk("strobe_off", 32'({mem_we, mem_re}), 32'h0);
    chk("grant_hold", 32'({grant_1, grant_0}), w ? 32'h2 : 32'h1);
    repeat (waits) begin
      step;
      chk("early_done", 32'({done_1, done_0}), 32'h0);
    end
    mem_rdy = 1'b1;
    step;
    mem_rdy = 1'b0;
    chk("done", 32'({done_1, done_0, tmo_err}), w ? 32'h4 : 32'h2);
    chk("done_grant", 32'({grant_1, grant_0}), w ? 32'h2 : 32'h1);
    if (w) req_1 = 1'b0; else req_0 = 1'b0;
    step;
    chk_idle("release");
  endtask

  initial begin
    rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0; mem_rdy = 1'b0;
    op_0 = 2'b00; op_1 = 2'b00; addr_0 = '0; addr_1 = '0;
    repeat (2) step;
    chk_idle("reset_outs");
    chk("reset_addr", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;
    step;
    chk_idle("post_reset_idle");
    req_0 = 1'b1; op_0 = 2'b00; addr_0 = 13'h0A5;
    txn(1'b0, 1'b0, 13'h0A5, 1);
    req_1 = 1'b1; op_1 = 2'b01; addr_1 = 13'h1FF;
    txn(1'b1, 1'b1, 13'h1FF, 0);
    // watchdog: cpu0 wins the tie, memory never answers, cpu1 waits behind it
    req_0 = 1'b1; op_0 = 2'b10; addr_0 = 13'h033;
    req_1 = 1'b1; op_1 = 2'b00; addr_1 = 13'h100;
    step;
    chk("tmo_grant", 32'({grant_1, grant_0}), 32'h1);
    chk("tmo_re", 32'({mem_we, mem_re}), 32'h1);
    step;
    repeat (62) step;
    chk("tmo_not_yet", 32'({done_1, done_0, tmo_err}), 32'h0);
    chk("tmo_owner", 32'({grant_1, grant_0}), 32'h1);
    step;
    chk("tmo_fire", 32'({done_1, done_0, tmo_err}), 32'h3);
    req_0 = 1'b0;
    step;
    chk_idle("tmo_release");
    step;
    chk("pending_1", 32'({grant_1, grant_0}), 32'h2);
    chk("pending_addr", 32'(mem_addr), 32'h100);
    // ready pulse during ISSUE must not complete the transaction
    mem_rdy = 1'b1;
    step;
    mem_rdy = 1'b0;
    chk("issue_rdy_ignored", 32'({done_1, done_0, mem_re}), 32'h0);
    step;
    step;
    chk("still_waiting", 32'({done_1, done_0, grant_1}), 32'h1);
    mem_rdy = 1'b1;
    step;
    mem_rdy = 1'b0;
    chk("late_done", 32'({done_1, done_0, tmo_err}), 32'h4);
    req_1 = 1'b0;
    step;
    chk_idle("late_release");
    req_0 = 1'b1; op_0 = 2'b11; addr_0 = 13'h0F0;
    txn(1'b0, 1'b0, 13'h0F0, 0);
    // cpu0 served last, so a tie goes to cpu1; reset it mid-WAIT
    req_0 = 1'b1; req_1 = 1'b1;
    step;
    chk("rr_tie_1", 32'({grant_1, grant_0}), 32'h2);
    step;
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_addr", 32'(mem_addr), 32'h0);
    step;
    rst_n = 1'b1;
    step;
    chk("reset_tie_0", 32'({grant_1, grant_0}), 32'h1);
    chk("reset_tie_addr", 32'(mem_addr), 32'h0F0);
    step;
    mem_rdy = 1'b1;
    step;
    mem_rdy = 1'b0;
    chk("reset_tie_done", 32'({done_1, done_0}), 32'h1);
    req_0 = 1'b0;
    step;
    step;
    chk("held_req_1", 32'({grant_1, grant_0}), 32'h2);
    step;
    mem_rdy = 1'b1;
    step;
    mem_rdy = 1'b0;
    chk("held_done_1", 32'({done_1, done_0}), 32'h2);
    req_1 = 1'b0;
    step;
    // alternating service from reset with both cores always requesting
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    op_0 = 2'b10; addr_0 = 13'h0AA; op_1 = 2'b11; addr_1 = 13'h155;
    req_0 = 1'b1; req_1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      txn(i[0], 1'b0, i[0] ? 13'h155 : 13'h0AA, 0);
      if (i[0]) req_1 = 1'b1; else req_0 = 1'b1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
